keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with debounce, auto-repeat and a valid/ready event interface. It drives one column at a time, synchronises and debounces the row inputs, and encodes each confirmed press as a linear key code plus a numeric/symbol flag. It sits between the keypad pins and the calculator input FSM, which consumes one event per handshake.

---
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot-low column drive, 2-flop row synchroniser,
// debounce/auto-repeat FSM and a single-entry valid/ready event register.
module keypad_scanner #(
    parameter int                   ROWS            = 4,
    parameter int                   COLS            = 4,
    parameter int                   SETTLE_CYCLES   = 4,
    parameter int                   DEBOUNCE_CYCLES = 16,
    parameter int                   REPEAT_CYCLES   = 0,
    parameter logic [ROWS*COLS-1:0] NUMERIC_MASK    = 16'h0777,
    localparam int                  KW              = $clog2(ROWS*COLS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [ROWS-1:0] row_sense,
    output logic [COLS-1:0] col_drive,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [KW-1:0]   key_code,
    output logic            key_numeric,
    output logic            key_repeat,
    output logic            overrun
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SETTLE_CYCLES);
    localparam int NW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [COLS-1:0] ONE_COL = COLS'(1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] rs_meta_q, rs_meta_d;
    logic [ROWS-1:0] rs_q, rs_d;
    logic            active_q, active_d;
    logic [CW-1:0]   c_q, c_d;
    logic [DW-1:0]   d_q, d_d;
    logic [NW-1:0]   n_q, n_d;
    logic [PW-1:0]   p_q, p_d;
    logic [RW-1:0]   r_q, r_d;

    logic [COLS-1:0] col_drive_q, col_drive_d;
    logic            key_valid_q, key_valid_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_numeric_q, key_numeric_d;
    logic            key_repeat_q, key_repeat_d;
    logic            overrun_q, overrun_d;

    logic            low_any;
    logic [RW-1:0]   low_idx;
    logic            row_hit;
    logic [CW-1:0]   c_next;
    logic [KW-1:0]   code_now;
    logic            emit;
    logic            emit_rep;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_SCAN;
            rs_meta_q     <= '1;
            rs_q          <= '1;
            active_q      <= 1'b0;
            c_q           <= '0;
            d_q           <= '0;
            n_q           <= '0;
            p_q           <= '0;
            r_q           <= '0;
            col_drive_q   <= '1;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_numeric_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rs_meta_q     <= rs_meta_d;
            rs_q          <= rs_d;
            active_q      <= active_d;
            c_q           <= c_d;
            d_q           <= d_d;
            n_q           <= n_d;
            p_q           <= p_d;
            r_q           <= r_d;
            col_drive_q   <= col_drive_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_numeric_q <= key_numeric_d;
            key_repeat_q  <= key_repeat_d;
            overrun_q     <= overrun_d;
        end
    end

    // Lowest-index active-low row wins when several rows are down.
    always_comb begin
        low_any = ~&rs_q;
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rs_q[i]) low_idx = RW'(i);
        end
    end

    assign row_hit  = !rs_q[r_q];
    assign c_next   = (c_q == CW'(COLS - 1)) ? '0 : c_q + 1'b1;
    assign code_now = KW'(r_q) * KW'(COLS) + KW'(c_q);

    // The first enabled cycle only turns the column on, so every column,
    // including column 0 after reset or enable, dwells a full SETTLE_CYCLES.
    always_comb begin
        rs_meta_d = row_sense;
        rs_d      = rs_meta_q;
        active_d  = enable;
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        n_d       = n_q;
        p_d       = p_q;
        r_d       = r_q;
        emit      = 1'b0;
        emit_rep  = 1'b0;
        if (!enable) begin
            state_d = S_SCAN;
            c_d     = '0;
            d_d     = '0;
            n_d     = '0;
            p_d     = '0;
        end else if (active_q) begin
            unique case (state_q)
                S_SCAN: begin
                    if (d_q == DW'(SETTLE_CYCLES - 1)) begin
                        d_d = '0;
                        if (low_any) begin
                            r_d     = low_idx;
                            n_d     = '0;
                            state_d = S_DEBOUNCE;
                        end else begin
                            c_d = c_next;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!row_hit) begin
                        state_d = S_SCAN;
                        d_d     = '0;
                    end else if (n_q == NW'(DEBOUNCE_CYCLES - 1)) begin
                        emit    = 1'b1;
                        p_d     = '0;
                        state_d = S_HELD;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!row_hit) begin
                        n_d     = '0;
                        state_d = S_RELEASE;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (p_q == PW'(REPEAT_CYCLES - 1)) begin
                            emit     = 1'b1;
                            emit_rep = 1'b1;
                            p_d      = '0;
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (row_hit) begin
                        state_d = S_HELD;
                    end else if (n_q == NW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d = S_SCAN;
                        c_d     = c_next;
                        d_d     = '0;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    // A transfer and a new emit in the same cycle reload without a bubble.
    always_comb begin
        col_drive_d   = enable ? ~(ONE_COL << c_d) : '1;
        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        key_numeric_d = key_numeric_q;
        key_repeat_d  = key_repeat_q;
        overrun_d     = overrun_q;
        if (emit && (!key_valid_q || key_ready)) begin
            key_valid_d   = 1'b1;
            key_code_d    = code_now;
            key_numeric_d = NUMERIC_MASK[code_now];
            key_repeat_d  = emit_rep;
        end else begin
            if (emit) overrun_d = 1'b1;
            if (key_valid_q && key_ready) key_valid_d = 1'b0;
        end
    end

    assign col_drive   = col_drive_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_numeric = key_numeric_q;
    assign key_repeat  = key_repeat_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural 4x4 keypad answers col_drive on
// row_sense, expected events are queued at press time and popped on transfer.
module tb_keypad_scanner;

    localparam int          ROWS   = 4;
    localparam int          COLS   = 4;
    localparam int          SETTLE = 4;
    localparam int          DEB    = 16;
    localparam int          REP    = 100;
    localparam logic [15:0] MASK   = 16'h0777;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        key_ready;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_numeric;
    logic        key_repeat;
    logic        overrun;
    logic [15:0] keys;

    typedef struct packed {
        logic [3:0] code;
        logic       num;
        logic       rep;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_ev;
    int  checks = 0;
    int  errors = 0;
    int  cyc_cnt = 0;
    int  last_ev_cycle = 0;

    always #5 clock = ~clock;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .NUMERIC_MASK(MASK)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .row_sense(row_sense),
        .col_drive(col_drive), .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .key_numeric(key_numeric), .key_repeat(key_repeat),
        .overrun(overrun)
    );

    // Pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row_sense = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !col_drive[c]) row_sense[r] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int code, input logic rep);
        ev_t         e;
        logic [15:0] m;
        m      = MASK;
        e.code = 4'(code);
        e.num  = m[code];
        e.rep  = rep;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_col(input string tag, input logic [3:0] pat, input int max, output int cyc);
        cyc = 0;
        while (col_drive !== pat && cyc < max) begin
            tick();
            cyc++;
        end
        if (col_drive !== pat) check_eq(tag, col_drive, pat);
    endtask

    task automatic wait_valid(input string tag, input int max, output int cyc);
        cyc = 0;
        while (key_valid !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
        if (key_valid !== 1'b1) check_eq(tag, key_valid, 1);
    endtask

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clock) begin
        if (key_valid === 1'b1 && key_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_event", exp_q.size(), 1);
            end else begin
                got_ev = exp_q.pop_front();
                check_eq("sb_code", key_code, got_ev.code);
                check_eq("sb_numeric", key_numeric, got_ev.num);
                check_eq("sb_repeat", key_repeat, got_ev.rep);
                if (got_ev.rep) check_eq("sb_repeat_interval", cyc_cnt - last_ev_cycle, REP);
            end
            last_ev_cycle = cyc_cnt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cyc;
        logic [3:0] exp_col;
        reset     = 1'b1;
        enable    = 1'b1;
        key_ready = 1'b1;
        keys      = '0;
        repeat (3) tick();
        check_eq("rst_col_drive", col_drive, 4'hF);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_numeric", key_numeric, 0);
        check_eq("rst_repeat", key_repeat, 0);
        check_eq("rst_overrun", overrun, 0);
        reset = 1'b0;

        // Idle scan: each column low for SETTLE cycles, wrapping.
        for (int k = 0; k < 40; k++) begin
            tick();
            exp_col = ~(4'b0001 << ((k / SETTLE) % COLS));
            check_eq("idle_col_drive", col_drive, exp_col);
            if (k % 8 == 7) check_eq("idle_valid", key_valid, 0);
        end

        // Clean press of row1/col2 (code 6).
        wait_col("press_wait_col0", 4'b1110, 20, cyc);
        push_ev(6, 1'b0);
        keys[6] = 1'b1;
        wait_col("press_wait_col2", 4'b1011, 20, cyc);
        wait_valid("press_valid", 40, cyc);
        check_eq("press_latency", cyc, SETTLE + DEB);
        check_eq("press_code", key_code, 6);
        repeat (40) tick();
        keys[6] = 1'b0;
        wait_col("press_resume_col3", 4'b0111, 40, cyc);
        check_eq("release_latency", cyc, DEB + 3);
        check_eq("press_queue_empty", exp_q.size(), 0);

        // Bouncing press of row2/col1 (code 9): one event only.
        push_ev(9, 1'b0);
        keys[9] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            repeat (3) tick();
            keys[9] = ~keys[9];
        end
        wait_valid("bounce_valid", 200, cyc);
        repeat (10) tick();
        keys[9] = 1'b0;
        wait_col("bounce_resume_col2", 4'b1011, 40, cyc);
        check_eq("bounce_release_latency", cyc, DEB + 3);
        check_eq("bounce_queue_empty", exp_q.size(), 0);

        // Auto-repeat on code 15 held 350 cycles past confirm.
        push_ev(15, 1'b0);
        for (int i = 0; i < 3; i++) push_ev(15, 1'b1);
        keys[15] = 1'b1;
        wait_valid("rep_press_valid", 60, cyc);
        repeat (350) tick();
        keys[15] = 1'b0;
        wait_col("rep_wrap_col0", 4'b1110, 40, cyc);
        check_eq("rep_release_latency", cyc, DEB + 3);
        check_eq("rep_queue_empty", exp_q.size(), 0);

        // Back-pressure: first event held, second dropped, overrun sticky.
        key_ready = 1'b0;
        push_ev(5, 1'b0);
        keys[5] = 1'b1;
        wait_valid("ovr_first_valid", 60, cyc);
        check_eq("ovr_first_code", key_code, 5);
        repeat (5) tick();
        keys[5] = 1'b0;
        wait_col("ovr_resume_col2", 4'b1011, 40, cyc);
        keys[10] = 1'b1;
        cyc = 0;
        while (overrun !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
            check_eq("ovr_hold_code", key_code, 5);
        end
        check_eq("ovr_set", overrun, 1);
        check_eq("ovr_latency", cyc, SETTLE + DEB);
        check_eq("ovr_valid_held", key_valid, 1);
        check_eq("ovr_numeric_held", key_numeric, 1);
        check_eq("ovr_repeat_held", key_repeat, 0);
        keys[10] = 1'b0;
        wait_col("ovr_resume_col3", 4'b0111, 40, cyc);
        key_ready = 1'b1;
        tick();
        check_eq("ovr_valid_drop", key_valid, 0);
        check_eq("ovr_sticky", overrun, 1);
        repeat (10) tick();
        check_eq("ovr_sticky_late", overrun, 1);
        check_eq("ovr_queue_empty", exp_q.size(), 0);

        // Reset while HELD with an event pending.
        key_ready = 1'b0;
        keys[9]   = 1'b1;
        wait_valid("rst_held_valid", 60, cyc);
        repeat (3) tick();
        check_eq("rst_pre_valid", key_valid, 1);
        reset = 1'b1;
        tick();
        check_eq("rst_held_col_drive", col_drive, 4'hF);
        check_eq("rst_held_valid", key_valid, 0);
        check_eq("rst_held_code", key_code, 0);
        check_eq("rst_held_numeric", key_numeric, 0);
        check_eq("rst_held_repeat", key_repeat, 0);
        check_eq("rst_held_overrun", overrun, 0);
        keys      = '0;
        key_ready = 1'b1;
        tick();
        reset = 1'b0;

        // Enable low mid-scan, then resume from column 0.
        wait_col("en_wait_col2", 4'b1011, 20, cyc);
        enable = 1'b0;
        tick();
        check_eq("en_off_col_drive", col_drive, 4'hF);
        repeat (3) tick();
        check_eq("en_off_col_drive_late", col_drive, 4'hF);
        enable = 1'b1;
        tick();
        check_eq("en_resume_col0", col_drive, 4'b1110);
        repeat (SETTLE) tick();
        check_eq("en_resume_col1", col_drive, 4'b1101);

        repeat (5) tick();
        check_eq("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
